// File: rtl/bus_arbiter.sv
// Shared RAM bus time-slicer between the 6502 CPU and the Pi SPI bridge.
// A free-running slot counter splits sys_clk into CPU cycles. Each cycle has one
// Pi window (PI_START..PI_START+PI_LEN-1) and one CPU phi2 window
// (CPU_START..SLOTS-1). All bus outputs are registered from the next-slot and
// next-state values, so each output is valid for the whole slot it belongs to.
module bus_arbiter #(
  parameter int SLOTS     = 16,
  parameter int PI_START  = 2,
  parameter int PI_LEN    = 4,
  parameter int CPU_START = 8
) (
  input  logic        sys_clk,
  input  logic        reset,
  input  logic        pi_pending,
  input  logic [16:0] pi_addr,
  input  logic        pi_rw_b,
  input  logic [7:0]  pi_wr_data,
  output logic        pi_done,
  output logic [7:0]  pi_rd_data,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_rw_b,
  input  logic [7:0]  cpu_wr_data,
  output logic        cpu_phi2,
  output logic [16:0] ram_addr,
  output logic        ram_oe_n,
  output logic        ram_we_n,
  input  logic [7:0]  ram_din,
  output logic [7:0]  ram_dout,
  output logic        ram_dout_oe
);

  localparam int SW = $clog2(SLOTS);
  localparam logic [SW-1:0] S_LAST     = SW'(SLOTS - 1);
  localparam logic [SW-1:0] S_PI_PRE   = SW'((PI_START == 0) ? SLOTS - 1 : PI_START - 1);
  localparam logic [SW-1:0] S_PI_START = SW'(PI_START);
  localparam logic [SW-1:0] S_PI_LAST  = SW'(PI_START + PI_LEN - 1);
  localparam logic [SW-1:0] S_CPU      = SW'(CPU_START);

  typedef enum logic [1:0] {IDLE, PI_ACCESS, DONE} state_t;

  state_t        state, state_nxt;
  logic [SW-1:0] slot, slot_nxt;
  logic          grant;

  // Pi request captured at grant so the window is immune to bridge changes
  logic [16:0] p_addr;
  logic        p_rw;
  logic [7:0]  p_wd;
  logic [16:0] a_pi;
  logic        rw_pi;
  logic [7:0]  wd_pi;

  logic        pi_win, cpu_win, pi_strobe, cpu_strobe;
  logic        phi2_nxt, oe_nxt, we_nxt, doe_nxt;
  logic [16:0] addr_nxt;
  logic [7:0]  dout_nxt;

  // Grant only from IDLE on the slot just before the Pi window
  assign grant = (state == IDLE) && (slot == S_PI_PRE) && pi_pending && !pi_done;

  // Slot counter: explicit compare-and-clear so SLOTS need not be a power of 2
  always_comb begin
    slot_nxt = (slot == S_LAST) ? '0 : slot + 1'b1;
  end

  // Slot counter register
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) slot <= '0;
    else       slot <= slot_nxt;
  end

  // FSM state register
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // FSM next state: a started window always runs to completion
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (grant) state_nxt = PI_ACCESS;
      PI_ACCESS: if (slot == S_PI_LAST) state_nxt = DONE;
      DONE:      if (!pi_pending) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // Latch the Pi request at grant
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      p_addr <= '0;
      p_rw   <= 1'b1;
      p_wd   <= '0;
    end else if (grant) begin
      p_addr <= pi_addr;
      p_rw   <= pi_rw_b;
      p_wd   <= pi_wr_data;
    end
  end

  // On the grant edge the latch is not yet loaded, so take the live request
  always_comb begin
    a_pi  = grant ? pi_addr    : p_addr;
    rw_pi = grant ? pi_rw_b    : p_rw;
    wd_pi = grant ? pi_wr_data : p_wd;
  end

  // Next-slot bus values; write strobes are inset one slot from each window edge
  always_comb begin
    pi_win     = (state_nxt == PI_ACCESS);
    cpu_win    = (slot_nxt >= S_CPU);
    pi_strobe  = (slot_nxt > S_PI_START) && (slot_nxt < S_PI_LAST);
    cpu_strobe = (slot_nxt > S_CPU) && (slot_nxt < S_LAST);
    phi2_nxt   = 1'b0;
    oe_nxt     = 1'b1;
    we_nxt     = 1'b1;
    doe_nxt    = 1'b0;
    addr_nxt   = ram_addr;
    dout_nxt   = ram_dout;
    if (pi_win) begin
      addr_nxt = a_pi;
      if (rw_pi) begin
        oe_nxt = 1'b0;
      end else begin
        dout_nxt = wd_pi;
        doe_nxt  = 1'b1;
        we_nxt   = !pi_strobe;
      end
    end else if (cpu_win) begin
      phi2_nxt = 1'b1;
      addr_nxt = {1'b0, cpu_addr};
      if (cpu_rw_b) begin
        oe_nxt = 1'b0;
      end else begin
        dout_nxt = cpu_wr_data;
        doe_nxt  = 1'b1;
        we_nxt   = !cpu_strobe;
      end
    end
  end

  // Registered bus outputs; reset drops all strobes immediately
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      cpu_phi2    <= 1'b0;
      ram_oe_n    <= 1'b1;
      ram_we_n    <= 1'b1;
      ram_dout_oe <= 1'b0;
      ram_addr    <= '0;
      ram_dout    <= '0;
    end else begin
      cpu_phi2    <= phi2_nxt;
      ram_oe_n    <= oe_nxt;
      ram_we_n    <= we_nxt;
      ram_dout_oe <= doe_nxt;
      ram_addr    <= addr_nxt;
      ram_dout    <= dout_nxt;
    end
  end

  // Handshake: done tracks DONE state; read data captured on the last window slot
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      pi_done    <= 1'b0;
      pi_rd_data <= '0;
    end else begin
      pi_done <= (state_nxt == DONE);
      if (state == PI_ACCESS && slot == S_PI_LAST && p_rw) pi_rd_data <= ram_din;
    end
  end

endmodule
